// File: rtl/issue_scoreboard_pkg.sv
// Shared types and constants for the issue scoreboard.
// Optional same-cycle writeback bypass is enabled with SB_WB_BYPASS_EN.
`ifndef ISSUE_SCOREBOARD_DEFS
`define ISSUE_SCOREBOARD_DEFS
`define REG_ADDR_BUS 4:0
`endif

package issue_scoreboard_pkg;

  localparam int REG_NUM    = 32;
  localparam int REG_ADDR_W = 5;
  localparam int TOT_W      = 4;

  typedef enum logic {
    SB_ST_RUN   = 1'b0,
    SB_ST_DRAIN = 1'b1
  } sb_state_e;

endpackage

// File: rtl/issue_scoreboard_if.sv
// idu/exu/writeback signal bundle seen by the issue scoreboard.
// The scoreboard side is the slave; the idu/exu side is the master.
interface issue_scoreboard_if;

  logic                dec_valid_i;
  logic [`REG_ADDR_BUS] rs1_addr_i;
  logic                rs1_re_i;
  logic [`REG_ADDR_BUS] rs2_addr_i;
  logic                rs2_re_i;
  logic [`REG_ADDR_BUS] rd_addr_i;
  logic                rd_we_i;
  logic                exu_ready_i;
  logic                wb_valid_i;
  logic [`REG_ADDR_BUS] wb_addr_i;
  logic                flush_i;
  logic                issue_o;
  logic                stall_o;
  logic                drain_o;
  logic                busy_o;
  logic [3:0]          outstanding_o;
  logic                sb_err_o;

  modport slave (
    input  dec_valid_i, rs1_addr_i, rs1_re_i,
    input  rs2_addr_i, rs2_re_i, rd_addr_i,
    input  rd_we_i, exu_ready_i, wb_valid_i,
    input  wb_addr_i, flush_i,
    output issue_o, stall_o, drain_o,
    output busy_o, outstanding_o, sb_err_o
  );

  modport master (
    output dec_valid_i, rs1_addr_i, rs1_re_i,
    output rs2_addr_i, rs2_re_i, rd_addr_i,
    output rd_we_i, exu_ready_i, wb_valid_i,
    output wb_addr_i, flush_i,
    input  issue_o, stall_o, drain_o,
    input  busy_o, outstanding_o, sb_err_o
  );

endinterface

// File: rtl/issue_scoreboard_counter_bank.sv
// Per-register pending-write counters for x1..x31 (x0 untracked).
// SB_WB_BYPASS_EN adds a "exactly one pending" flag per register.
module sb_counter_bank
  import issue_scoreboard_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                inc_en_i,
  input  logic [`REG_ADDR_BUS] inc_addr_i,
  input  logic                dec_en_i,
  input  logic [`REG_ADDR_BUS] dec_addr_i,
`ifdef SB_WB_BYPASS_EN
  output logic [REG_NUM-1:0]  one_o,
`endif
  output logic [REG_NUM-1:0]  zero_o,
  output logic [REG_NUM-1:0]  sat_o
);

  localparam logic [CNT_W-1:0] One = CNT_W'(1);

  assign zero_o[0] = 1'b1;
  assign sat_o[0]  = 1'b0;
`ifdef SB_WB_BYPASS_EN
  assign one_o[0]  = 1'b0;
`endif

  for (genvar i = 1; i < REG_NUM; i++) begin : g_reg
    localparam logic [REG_ADDR_W-1:0] Idx = REG_ADDR_W'(i);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic inc, dec;

    assign inc = inc_en_i & (inc_addr_i == Idx);
    assign dec = dec_en_i & (dec_addr_i == Idx);

    // Coincident inc and dec cancel out.
    always_comb begin
      cnt_d = cnt_q;
      if (inc & ~dec)
        cnt_d = cnt_q + One;
      else if (dec & ~inc)
        cnt_d = cnt_q - One;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        cnt_q <= '0;
      else
        cnt_q <= cnt_d;
    end

    assign zero_o[i] = (cnt_q == '0);
    assign sat_o[i]  = &cnt_q;
`ifdef SB_WB_BYPASS_EN
    assign one_o[i]  = (cnt_q == One);
`endif
  end

endmodule

// File: rtl/issue_scoreboard.sv
// Issue gate between idu and exu: RAW/capacity checks plus flush drain.
// Build with SB_WB_BYPASS_EN to let a retiring write clear a hazard.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 2
) (
  input logic               clk,
  input logic               rst_n,
  issue_scoreboard_if.slave sb_if
);

  localparam logic [TOT_W-1:0] MaxOut = TOT_W'(MAX_OUTSTANDING);

  logic [REG_NUM-1:0] zero, sat;
  sb_state_e          state_q;
  logic [TOT_W-1:0]   total_q, total_d;
  logic               err_q;
  logic               run, by1, by2, hz1, hz2, raw;
  logic               full, rd_sat, issue;
  logic               inc_en, dec_en, err_set, wb_nz;

`ifdef SB_WB_BYPASS_EN
  logic [REG_NUM-1:0] one;
`endif

  sb_counter_bank #(.CNT_W(CNT_W)) u_bank (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc_en_i   (inc_en),
    .inc_addr_i (sb_if.rd_addr_i),
    .dec_en_i   (dec_en),
    .dec_addr_i (sb_if.wb_addr_i),
`ifdef SB_WB_BYPASS_EN
    .one_o      (one),
`endif
    .zero_o     (zero),
    .sat_o      (sat)
  );

  assign run = (state_q == SB_ST_RUN);

`ifdef SB_WB_BYPASS_EN
  assign by1 = run & sb_if.wb_valid_i
             & (sb_if.wb_addr_i == sb_if.rs1_addr_i)
             & one[sb_if.rs1_addr_i];
  assign by2 = run & sb_if.wb_valid_i
             & (sb_if.wb_addr_i == sb_if.rs2_addr_i)
             & one[sb_if.rs2_addr_i];
`else
  assign by1 = 1'b0;
  assign by2 = 1'b0;
`endif

  assign hz1 = sb_if.rs1_re_i & ~zero[sb_if.rs1_addr_i] & ~by1;
  assign hz2 = sb_if.rs2_re_i & ~zero[sb_if.rs2_addr_i] & ~by2;
  assign raw = hz1 | hz2;

  assign full   = (total_q == MaxOut);
  assign rd_sat = sat[sb_if.rd_addr_i];

  assign issue = run & sb_if.dec_valid_i & sb_if.exu_ready_i
               & ~raw & ~sb_if.flush_i
               & ~(sb_if.rd_we_i & (full | rd_sat));

  assign wb_nz   = sb_if.wb_valid_i & (sb_if.wb_addr_i != '0);
  assign inc_en  = issue & sb_if.rd_we_i & (sb_if.rd_addr_i != '0);
  assign dec_en  = wb_nz & ~zero[sb_if.wb_addr_i];
  assign err_set = wb_nz & zero[sb_if.wb_addr_i];

  assign total_d = total_q + TOT_W'(inc_en) - TOT_W'(dec_en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SB_ST_RUN;
      total_q <= '0;
      err_q   <= 1'b0;
    end else begin
      total_q <= total_d;
      if (err_set)
        err_q <= 1'b1;
      unique case (state_q)
        SB_ST_RUN:
          if (sb_if.flush_i && total_d != '0)
            state_q <= SB_ST_DRAIN;
        SB_ST_DRAIN:
          if (total_d == '0)
            state_q <= SB_ST_RUN;
        default: state_q <= SB_ST_RUN;
      endcase
    end
  end

  assign sb_if.issue_o       = issue;
  assign sb_if.stall_o       = sb_if.dec_valid_i & ~issue;
  assign sb_if.drain_o       = (state_q == SB_ST_DRAIN);
  assign sb_if.busy_o        = (total_q != '0);
  assign sb_if.outstanding_o = total_q;
  assign sb_if.sb_err_o      = err_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench: hand vectors, corner sequences, random vs model.
module tb_issue_scoreboard;

`ifdef SB_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int MAXO = 4;
  localparam int CMAX = 3;

  typedef struct {
    bit dv; int rs1; bit r1e; int rs2; bit r2e;
    int rd; bit we; bit rdy; bit wbv; int wba; bit fl;
  } stim_t;

  typedef struct {
    stim_t s; bit iss; bit stl; int out;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  issue_scoreboard_if bus ();

  issue_scoreboard #(.MAX_OUTSTANDING(MAXO), .CNT_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb_if (bus)
  );

  int total = 0;
  int bad = 0;

  int  mcnt [32];
  int  mtot;
  bit  mdrain, merr;

  logic o_iss, o_stl, o_drn, o_busy, o_err;
  logic [3:0] o_out;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic stim_t S(bit dv, int rs1, bit r1e, int rs2,
                              bit r2e, int rd, bit we, bit rdy,
                              bit wbv, int wba, bit fl);
    stim_t s;
    s.dv = dv; s.rs1 = rs1; s.r1e = r1e; s.rs2 = rs2; s.r2e = r2e;
    s.rd = rd; s.we = we; s.rdy = rdy; s.wbv = wbv; s.wba = wba;
    s.fl = fl;
    return s;
  endfunction

  function automatic stim_t I(int rd);
    return S(1, 0, 0, 0, 0, rd, 1, 1, 0, 0, 0);
  endfunction

  function automatic stim_t IW(int rd, int a);
    return S(1, 0, 0, 0, 0, rd, 1, 1, 1, a, 0);
  endfunction

  function automatic stim_t W(int a);
    return S(0, 0, 0, 0, 0, 0, 0, 0, 1, a, 0);
  endfunction

  function automatic stim_t IDLE();
    return S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic mreset();
    foreach (mcnt[i]) mcnt[i] = 0;
    mtot = 0; mdrain = 0; merr = 0;
  endtask

  function automatic bit mhaz(stim_t s, int rs, bit re);
    bit byp_ok;
    if (!re || rs == 0 || mcnt[rs] == 0) return 0;
    byp_ok = BYP && !mdrain && s.wbv && s.wba == rs && mcnt[rs] == 1;
    return !byp_ok;
  endfunction

  task automatic drive(stim_t s);
    bus.dec_valid_i = s.dv;
    bus.rs1_addr_i  = 5'(s.rs1);
    bus.rs1_re_i    = s.r1e;
    bus.rs2_addr_i  = 5'(s.rs2);
    bus.rs2_re_i    = s.r2e;
    bus.rd_addr_i   = 5'(s.rd);
    bus.rd_we_i     = s.we;
    bus.exu_ready_i = s.rdy;
    bus.wb_valid_i  = s.wbv;
    bus.wb_addr_i   = 5'(s.wba);
    bus.flush_i     = s.fl;
  endtask

  // One clock: drive at negedge, compare vs model, advance the model.
  task automatic step(stim_t s);
    bit e_iss, full, sat, inc, dec;
    @(negedge clk);
    drive(s);
    #1;
    o_iss = bus.issue_o; o_stl = bus.stall_o; o_drn = bus.drain_o;
    o_busy = bus.busy_o; o_out = bus.outstanding_o;
    o_err = bus.sb_err_o;
    full  = (mtot == MAXO);
    sat   = s.we && s.rd != 0 && mcnt[s.rd] == CMAX;
    e_iss = !mdrain && s.dv && s.rdy && !s.fl
            && !mhaz(s, s.rs1, s.r1e) && !mhaz(s, s.rs2, s.r2e)
            && !(s.we && (full || sat));
    chk("issue", 32'(o_iss), 32'(e_iss));
    chk("stall", 32'(o_stl), 32'(s.dv && !e_iss));
    chk("drain", 32'(o_drn), 32'(mdrain));
    chk("busy", 32'(o_busy), 32'(mtot != 0));
    chk("outstanding", 32'(o_out), 32'(mtot));
    chk("sb_err", 32'(o_err), 32'(merr));
    inc = e_iss && s.we && s.rd != 0;
    dec = s.wbv && s.wba != 0 && mcnt[s.wba] != 0;
    if (s.wbv && s.wba != 0 && mcnt[s.wba] == 0) merr = 1;
    if (inc) mcnt[s.rd]++;
    if (dec) mcnt[s.wba]--;
    mtot = mtot + int'(inc) - int'(dec);
    if (!mdrain) begin
      if (s.fl && mtot != 0) mdrain = 1;
    end else if (mtot == 0) begin
      mdrain = 0;
    end
  endtask

  task automatic chk_all_zero(string nm);
    chk({nm, "_issue"}, 32'(bus.issue_o), 0);
    chk({nm, "_stall"}, 32'(bus.stall_o), 0);
    chk({nm, "_drain"}, 32'(bus.drain_o), 0);
    chk({nm, "_busy"}, 32'(bus.busy_o), 0);
    chk({nm, "_out"}, 32'(bus.outstanding_o), 0);
    chk({nm, "_err"}, 32'(bus.sb_err_o), 0);
  endtask

  vec_t tbl[$];

  initial begin
    stim_t s;
    int pend[$];

    drive(IDLE());
    mreset();
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    tbl.push_back('{I(1), 1, 0, 0});
    tbl.push_back('{I(2), 1, 0, 1});
    tbl.push_back('{I(3), 1, 0, 2});
    tbl.push_back('{I(4), 1, 0, 3});
    tbl.push_back('{I(6), 0, 1, 4});
    tbl.push_back('{IW(6, 1), 0, 1, 4});
    tbl.push_back('{I(6), 1, 0, 3});
    tbl.push_back('{W(2), 0, 0, 4});
    tbl.push_back('{W(3), 0, 0, 3});
    tbl.push_back('{W(4), 0, 0, 2});
    tbl.push_back('{I(7), 1, 0, 1});
    tbl.push_back('{I(7), 1, 0, 2});
    tbl.push_back('{IW(7, 6), 1, 0, 3});
    tbl.push_back('{I(7), 0, 1, 3});
    tbl.push_back('{IW(7, 7), 0, 1, 3});
    tbl.push_back('{I(7), 1, 0, 2});
    tbl.push_back('{IW(9, 7), 1, 0, 3});
    tbl.push_back('{IW(9, 9), 1, 0, 3});
    tbl.push_back('{W(9), 0, 0, 3});
    tbl.push_back('{I(0), 1, 0, 2});
    tbl.push_back('{S(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), 0, 1, 2});
    tbl.push_back('{S(1, 7, 1, 0, 0, 0, 0, 1, 0, 0, 0), 0, 1, 2});
    tbl.push_back('{S(1, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0), 1, 0, 2});
    tbl.push_back('{W(7), 0, 0, 2});
    tbl.push_back('{W(7), 0, 0, 1});
    tbl.push_back('{W(0), 0, 0, 0});

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].s);
      chk($sformatf("tbl%0d_issue", i), 32'(o_iss), 32'(tbl[i].iss));
      chk($sformatf("tbl%0d_stall", i), 32'(o_stl), 32'(tbl[i].stl));
      chk($sformatf("tbl%0d_out", i), 32'(o_out), 32'(tbl[i].out));
      chk($sformatf("tbl%0d_err", i), 32'(o_err), 0);
    end

    // RAW stall released by writeback
    step(I(5));
    chk("raw_first_issue", 32'(o_iss), 1);
    step(S(1, 5, 1, 0, 0, 0, 0, 1, 0, 0, 0));
    chk("raw_stall", 32'(o_stl), 1);
    step(S(1, 5, 1, 0, 0, 0, 0, 1, 1, 5, 0));
    chk("raw_wb_cycle_issue", 32'(o_iss), 32'(BYP));
    step(S(1, 5, 1, 0, 0, 0, 0, 1, 0, 0, 0));
    chk("raw_after_wb_issue", 32'(o_iss), 1);

    // Flush with two writes in flight
    step(I(10));
    step(I(11));
    step(S(1, 0, 0, 0, 0, 12, 1, 1, 0, 0, 1));
    chk("flush_cycle_issue", 32'(o_iss), 0);
    step(I(12));
    chk("drain_set", 32'(o_drn), 1);
    chk("drain_issue", 32'(o_iss), 0);
    step(S(1, 0, 0, 0, 0, 12, 1, 1, 1, 10, 1));
    chk("drain_flush_again", 32'(o_drn), 1);
    step(IW(12, 11));
    chk("drain_last_wb", 32'(o_drn), 1);
    step(I(12));
    chk("drain_clear", 32'(o_drn), 0);
    chk("resume_issue", 32'(o_iss), 1);
    step(W(12));
    s = S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(s);
    step(IDLE());
    chk("flush_empty_nodrain", 32'(o_drn), 0);

    // Sticky error, then async reset in DRAIN
    step(W(12));
    chk("err_before", 32'(o_err), 0);
    step(IDLE());
    chk("err_set", 32'(o_err), 1);
    step(I(13));
    step(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    step(IDLE());
    chk("err_sticky", 32'(o_err), 1);
    chk("rst_pre_drain", 32'(o_drn), 1);
    chk("rst_pre_busy", 32'(o_busy), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    mreset();
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      s = S(($urandom % 4) != 0, $urandom % 16, $urandom % 2,
            $urandom % 16, $urandom % 2, $urandom % 16,
            ($urandom % 4) != 0, ($urandom % 5) != 0,
            0, 0, ($urandom % 40) == 0);
      pend.delete();
      for (int r = 1; r < 32; r++)
        if (mcnt[r] != 0) pend.push_back(r);
      if (pend.size() != 0 && ($urandom % 3) != 0) begin
        s.wbv = 1;
        s.wba = pend[$urandom % pend.size()];
      end else if (($urandom % 200) == 0) begin
        s.wbv = 1;
        s.wba = $urandom % 32;
      end
      step(s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Issue controller between idu and exu.
- Tracks outstanding register writes in a per-register scoreboard and gates decoded instructions into exu.
- Detects RAW hazards on rs1/rs2 against in-flight rd writes and stalls ifu/idu until writeback clears them.
- Sequences pipeline flush: blocks issue until all in-flight writes have drained.

Parameters:
- MAX_OUTSTANDING, 4, total in-flight register writes allowed (1..15).
- CNT_W, 2, width of each per-register pending counter; per-register max is 2^CNT_W-1.

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- dec_valid_i  input  1  idu holds a decoded instruction
- rs1_addr_i  input  `REG_ADDR_BUS  source 1 from idu
- rs1_re_i  input  1  instruction reads rs1
- rs2_addr_i  input  `REG_ADDR_BUS  source 2 from idu
- rs2_re_i  input  1  instruction reads rs2
- rd_addr_i  input  `REG_ADDR_BUS  destination from idu
- rd_we_i  input  1  instruction writes rd
- exu_ready_i  input  1  exu accepts an instruction this cycle
- wb_valid_i  input  1  a register write retires this cycle
- wb_addr_i  input  `REG_ADDR_BUS  retiring destination
- flush_i  input  1  pipeline flush request (1-cycle pulse)
- issue_o  output  1  instruction transferred to exu this cycle
- stall_o  output  1  hold ifu/idu (dec_valid_i & ~issue_o)
- drain_o  output  1  state == DRAIN
- busy_o  output  1  any write outstanding
- outstanding_o  output  4  total in-flight writes
- sb_err_o  output  1  sticky: writeback to a register with zero pending

Behaviour:
- Reset (async, rst_n=0): all per-register counters 0, total 0, state RUN, sb_err_o 0.
- Reset outputs: issue_o 0, stall_o 0, drain_o 0, busy_o 0, outstanding_o 0.
- Reset mid-operation discards all pending state immediately.
- Register x0 is never tracked. Hazard checks and counter updates ignore address 0. Writebacks to x0 are ignored.
- raw = (rs1_re_i & cnt[rs1]!=0) | (rs2_re_i & cnt[rs2]!=0).
- full = total == MAX_OUTSTANDING.
- sat = rd_we_i & rd!=0 & cnt[rd] == max.
- issue_o = state==RUN & dec_valid_i & exu_ready_i & ~raw & ~(rd_we_i & (full | sat)) & ~flush_i.
- issue_o is combinational from current state; counters update at the next clk edge. Zero-cycle issue latency.
- stall_o = dec_valid_i & ~issue_o. A stall caused by exu_ready_i=0 is also flagged.
- Counter update per edge: cnt[rd] +1 if (issue_o & rd_we_i & rd!=0); cnt[wb_addr] -1 if (wb_valid_i & wb_addr!=0 & cnt!=0). The total counter is updated the same way.
- Same register incremented and decremented on the same edge: net unchanged.
- WAW to the same rd is permitted up to the per-register max. Writeback is in order.
- Writeback with cnt[wb_addr]==0 and wb_addr!=0: no decrement; sb_err_o set until reset.
- FSM:
  - RUN: on flush_i, go to DRAIN if total (after this edge's update) != 0; otherwise stay in RUN.
  - DRAIN: issue_o forced 0. Writebacks continue to decrement. Return to RUN on the edge where total reaches 0.
  - flush_i while in DRAIN has no additional effect.
- busy_o = total != 0.

Optional Feature:
- Macro SB_WB_BYPASS_EN.
- Defined: a source whose only pending write retires this cycle (wb_valid_i & wb_addr_i==rs & cnt[rs]==1) is not a hazard. The instruction issues in the same cycle; exu takes the forwarded value.
- Undefined: such a source stalls one extra cycle until the counter clears.
- Bypass never applies in DRAIN.

Decomposition:
- Shared defines file: `REG_ADDR_BUS and REG_NUM (32), plus FSM state encodings SB_ST_RUN / SB_ST_DRAIN.
- One sub-module, sb_counter_bank: 31 CNT_W-bit counters with inc/dec address ports, zero flags, and saturation flags.
- The FSM and issue logic live in issue_scoreboard.

Test Plan:
- RAW stall: issue rd=x5, then dec rs1=x5 re=1. Expect stall_o=1 until wb_valid_i wb_addr=5; issue_o rises the cycle after (same cycle with SB_WB_BYPASS_EN).
- Capacity: issue 4 writes to x1..x4 with no wb. A 5th (rd=x6, no RAW) expects stall_o=1 and outstanding_o=4. One wb releases it.
- Saturation/WAW: 3 issues to rd=x7 give cnt=3; a 4th to x7 stalls. A wb to x7 lets it issue next cycle.
- Simultaneous: issue rd=x9 while wb x9 retires (cnt was 1). Expect cnt[x9]=1 and outstanding_o unchanged.
- Flush: 2 outstanding, flush_i pulse. Expect drain_o=1 and issue_o=0 with dec_valid_i=1; after 2 wbs, drain_o=0 and issue resumes.
- Errors/x0: issue rd=x0 leaves outstanding_o=0. wb x12 with cnt 0 sets sb_err_o=1, which stays until rst_n=0. Async reset mid-DRAIN clears all outputs without waiting for clk.
